// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO, redirect flush/drop.
// Optional same-cycle bypass of fetched data when the queue is empty: define IFQ_BYPASS_EN.
module inst_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int IW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [AW-1:0]            imem_addr,
   input  logic                     imem_ack,
   input  logic [IW-1:0]            imem_data,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [IW-1:0]            inst_out,
   output logic [AW-1:0]            inst_pc,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_pc,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] FULL = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]    state, state_next;
   logic          started;
   logic [AW-1:0] fetch_pc, drop_addr;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [IW-1:0] inst_mem [DEPTH];
   logic [AW-1:0] pc_mem   [DEPTH];
   logic          empty, acked, enq, deq;

   // started keeps the request low until the first edge after reset releases
   assign imem_req  = started && ((state == DROP) || (state == RUN && count != CNT_FULL));
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;
   assign q_count   = count;
   assign empty     = (count == '0);
   assign acked     = imem_req && imem_ack;
   assign deq       = !empty && inst_ready;

`ifdef IFQ_BYPASS_EN
   logic bypass;
   assign bypass     = empty && acked && (state == RUN) && !redirect;
   assign inst_valid = !empty || bypass;
   assign inst_out   = !empty ? inst_mem[rd_ptr] : (bypass ? imem_data : '0);
   assign inst_pc    = !empty ? pc_mem[rd_ptr]   : (bypass ? imem_addr : '0);
   assign enq        = acked && (state == RUN) && !redirect && !(bypass && inst_ready);
`else
   assign inst_valid = !empty;
   assign inst_out   = empty ? '0 : inst_mem[rd_ptr];
   assign inst_pc    = empty ? '0 : pc_mem[rd_ptr];
   assign enq        = acked && (state == RUN) && !redirect;
`endif

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            // an unacknowledged request must be drained before refetching
            if (redirect)
               state_next = (imem_req && !imem_ack) ? DROP : RUN;
            else if (enq && !deq && count == CNT_FULL - 1'b1)
               state_next = FULL;
         end
         FULL: begin
            if (redirect || deq)
               state_next = RUN;
         end
         DROP: begin
            if (imem_ack)
               state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         started   <= 1'b0;
         fetch_pc  <= '0;
         drop_addr <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         started <= 1'b1;
         state   <= state_next;
         if (redirect)
            fetch_pc <= redirect_pc;
         else if (acked && state == RUN)
            fetch_pc <= fetch_pc + 1'b1;
         if (state == RUN && redirect && imem_req && !imem_ack)
            drop_addr <= fetch_pc;
         // redirect flushes; a dequeue in that same cycle is simply absorbed by the flush
         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq)
               wr_ptr <= wr_ptr + 1'b1;
            if (deq)
               rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)
               count <= count + 1'b1;
            else if (!enq && deq)
               count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         inst_mem[wr_ptr] <= imem_data;
         pc_mem[wr_ptr]   <= imem_addr;
      end
   end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, queue entries (power of 2, min 2); AW, 12, word address width; IW, 16, instruction width.
REQ-002 Port clk  in  1  single clock, all state on rising edge.
REQ-003 Port rst  in  1  asynchronous, active-high reset.
REQ-004 Port imem_req  out  1  fetch request to instruction memory.
REQ-005 Port imem_addr  out  AW  word address of current request.
REQ-006 Port imem_ack  in  1  memory accepts request; imem_data valid this cycle.
REQ-007 Port imem_data  in  IW  fetched instruction.
REQ-008 Port inst_valid  out  1  inst_out/inst_pc valid to the controller/datapath.
REQ-009 Port inst_ready  in  1  consumer takes instruction this cycle.
REQ-010 Port inst_out  out  IW  instruction; bits [IW-1:IW-4] are the opcode.
REQ-011 Port inst_pc  out  AW  address of inst_out.
REQ-012 Port redirect  in  1  taken jump/branch; flush and refetch.
REQ-013 Port redirect_pc  in  AW  new fetch address.
REQ-014 Port q_count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-015 FSM states SHALL be RUN, FULL, DROP.
REQ-016 One request outstanding max; imem_req, once high, SHALL stay high with imem_addr stable until imem_ack.
REQ-017 RUN: imem_req high when q_count<DEPTH; on imem_ack, enqueue {imem_data, imem_addr}, fetch_pc <= fetch_pc+1 (mod 2^AW, wrap 0xFFF->0x000).
REQ-018 RUN->FULL when enqueue makes q_count==DEPTH; FULL: imem_req low; FULL->RUN on any dequeue.
REQ-019 Dequeue SHALL occur when inst_valid && inst_ready; inst_valid = (q_count!=0); inst_out/inst_pc show oldest entry.
REQ-020 Simultaneous enqueue and dequeue SHALL leave q_count unchanged; pointers wrap modulo DEPTH.
REQ-021 redirect SHALL flush queue (q_count=0, inst_valid=0 next cycle) and set fetch_pc <= redirect_pc; redirect has priority over enqueue.
REQ-022 A dequeue in the redirect cycle SHALL complete (that instruction is consumed).
REQ-023 redirect with imem_req high and imem_ack low SHALL go to DROP: hold old request until imem_ack, discard its data, then RUN from redirect_pc.
REQ-024 redirect coincident with imem_ack SHALL discard that data, stay/return RUN, next request from redirect_pc.
REQ-025 redirect in DROP SHALL update fetch_pc to the newest redirect_pc and remain in DROP.
REQ-026 Data SHALL never be enqueued while in DROP.

Reset
REQ-027 rst SHALL immediately set: state RUN, fetch_pc 0, q_count 0, pointers 0, imem_req 0, inst_valid 0, inst_out 0, inst_pc 0.
REQ-028 First imem_req SHALL assert in the first cycle after rst deasserts, addr 0.
REQ-029 rst mid-request SHALL abandon the outstanding request; a late imem_ack after reset with imem_req low SHALL be ignored.

Configuration
REQ-030 Macro IFQ_BYPASS_EN defined: when q_count==0, imem_ack, not DROP, no redirect, inst_valid SHALL assert same cycle with inst_out=imem_data, inst_pc=imem_addr; if inst_ready also high, entry not enqueued.
REQ-031 IFQ_BYPASS_EN undefined: fetched data SHALL appear on inst_out no earlier than the cycle after imem_ack (1-cycle latency); bypass logic absent.

Verification
REQ-032 Reset, memory acks every cycle, inst_ready=1 -> inst_pc sequence 0,1,2,3...; inst_out matches memory image.
REQ-033 inst_ready=0, acks every cycle -> q_count reaches 4, state FULL, imem_req low, imem_addr=4; one dequeue -> request addr 4 reissued.
REQ-034 Request addr 5 outstanding, redirect=1 redirect_pc=0x020, ack 3 cycles later -> data discarded, next request addr 0x020, no inst_valid for addr 5.
REQ-035 redirect coincident with ack of addr 7 -> q_count 0 next cycle, next imem_addr=redirect_pc.
REQ-036 fetch_pc=0xFFF, ack -> next imem_addr 0x000.
REQ-037 With IFQ_BYPASS_EN, empty queue, ack data 0xA123, inst_ready=1 -> inst_valid=1, inst_out=0xA123 same cycle, q_count stays 0; without macro -> appears next cycle.
